// File: rtl/hyper_pkg.sv
// Shared definitions for the HyperBus responder: FSM states, CA field positions
// and default register values.
package hyper_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CA,
        ST_LAT,
        ST_WDATA,
        ST_RDATA,
        ST_REGW,
        ST_DONE
    } state_t;

    localparam int CA_RW    = 47;
    localparam int CA_AS    = 46;
    localparam int CA_BT    = 45;
    localparam int CA_BEATS = 6;

    localparam logic [15:0] ID0_DEF = 16'h0C81;
    localparam logic [15:0] CR0_DEF = 16'h8F1F;

endpackage

// File: rtl/hyper_resp_mem.sv
// Single-port 16-bit RAM with per-byte write enables and a registered read port.
module hyper_resp_mem #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    input  logic [1:0]    be,
    input  logic          we,
    output logic [15:0]   rdata
);

    logic [15:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            if (be[1]) mem[addr][15:8] <= wdata[15:8];
            if (be[0]) mem[addr][7:0]  <= wdata[7:0];
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/hyper_resp.sv
// HyperBus device-side responder serving memory and ID0/CR0 register accesses.
//   state    | meaning
//   ST_IDLE  | CS released, waiting for CS falling
//   ST_CA    | shifting in the 6-byte command/address word
//   ST_LAT   | counting initial latency beats
//   ST_WDATA | memory write data, committed per word
//   ST_RDATA | read data (memory or register) driven on DQ/RWDS
//   ST_REGW  | capturing the 2-byte CR0 write
//   ST_DONE  | access complete, beats ignored until CS release
module hyper_resp
    import hyper_pkg::*;
#(
    parameter int          MEM_AW    = 10,
    parameter int          LAT_BEATS = 22,
    parameter logic [15:0] ID0_VAL   = ID0_DEF,
    parameter logic [15:0] CR0_RST   = CR0_DEF
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic        dram_ck,
    input  logic        dram_cs_l,
    input  logic        dram_rst_l,
    input  logic [7:0]  dram_dq_in,
    output logic [7:0]  dram_dq_out,
    output logic        dram_dq_oe_l,
    input  logic        dram_rwds_in,
    output logic        dram_rwds_out,
    output logic        dram_rwds_oe_l,
    output logic [15:0] cr0,
    output logic        busy
);

    localparam int CNT_MAX = (LAT_BEATS > CA_BEATS) ? LAT_BEATS : CA_BEATS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t              state, state_nx;
    logic                ck_q, cs_q, beat;
    logic [47:0]         ca, ca_shift;
    logic [31:0]         ca_wa;
    logic [CNT_W-1:0]    cnt;
    logic                odd;
    logic [7:0]          hi_byte;
    logic                hi_mask;
    logic [MEM_AW-1:0]   addr, mem_addr, wr_addr;
    logic                wr_pend;
    logic [15:0]         wr_data, mem_rdata, rd_word;
    logic [1:0]          wr_be;
    logic                ca_unused;

    assign beat     = !dram_cs_l && (dram_ck != ck_q);
    assign ca_shift = {ca[39:0], dram_dq_in};
    assign ca_wa    = {ca_shift[44:16], ca_shift[2:0]};
    assign busy     = (state != ST_IDLE);
    assign ca_unused = ^{ca[45:40], ca_shift[CA_BT], ca_shift[15:3], ca_wa[31:MEM_AW]};

    // Register space ignores the memory and never advances the address.
    assign rd_word = ca[CA_AS] ? ((addr == '0) ? ID0_VAL : cr0) : mem_rdata;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l)           state <= ST_IDLE;
        else if (!dram_rst_l) state <= ST_IDLE;
        else                  state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (dram_cs_l) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (cs_q) state_nx = ST_CA;
                ST_CA:    if (beat && cnt == '0)
                              state_nx = (!ca_shift[CA_RW] && ca_shift[CA_AS]) ? ST_REGW : ST_LAT;
                ST_LAT:   if (beat && cnt == '0)
                              state_nx = ca[CA_RW] ? ST_RDATA : ST_WDATA;
                ST_REGW:  if (beat && odd) state_nx = ST_DONE;
                default:  ;
            endcase
        end
    end

    // Prefetch the next word on the low-byte beat so back-to-back beats never stall.
    always_comb begin
        mem_addr = addr;
        if (wr_pend)
            mem_addr = wr_addr;
        else if (state == ST_RDATA && beat && odd)
            mem_addr = addr + 1'b1;
    end

    hyper_resp_mem #(.AW(MEM_AW)) u_mem (
        .clk   (clk),
        .addr  (mem_addr),
        .wdata (wr_data),
        .be    (wr_be),
        .we    (wr_pend),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            ck_q           <= 1'b0;
            cs_q           <= 1'b1;
            ca             <= '0;
            cnt            <= '0;
            odd            <= 1'b0;
            hi_byte        <= '0;
            hi_mask        <= 1'b0;
            addr           <= '0;
            wr_pend        <= 1'b0;
            wr_addr        <= '0;
            wr_data        <= '0;
            wr_be          <= '0;
            dram_dq_out    <= '0;
            dram_rwds_out  <= 1'b0;
            dram_dq_oe_l   <= 1'b1;
            dram_rwds_oe_l <= 1'b1;
            cr0            <= CR0_RST;
        end else if (!dram_rst_l) begin
            ck_q           <= 1'b0;
            cs_q           <= 1'b1;
            ca             <= '0;
            cnt            <= '0;
            odd            <= 1'b0;
            hi_byte        <= '0;
            hi_mask        <= 1'b0;
            addr           <= '0;
            wr_pend        <= 1'b0;
            wr_addr        <= '0;
            wr_data        <= '0;
            wr_be          <= '0;
            dram_dq_out    <= '0;
            dram_rwds_out  <= 1'b0;
            dram_dq_oe_l   <= 1'b1;
            dram_rwds_oe_l <= 1'b1;
            cr0            <= CR0_RST;
        end else begin
            ck_q    <= dram_ck;
            cs_q    <= dram_cs_l;
            wr_pend <= 1'b0;
            if (dram_cs_l) begin
                dram_dq_oe_l   <= 1'b1;
                dram_rwds_oe_l <= 1'b1;
                dram_rwds_out  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: if (cs_q) begin
                        dram_rwds_oe_l <= 1'b0;
                        dram_rwds_out  <= 1'b1;
                        cnt            <= CNT_W'(CA_BEATS - 1);
                    end
                    ST_CA: if (beat) begin
                        ca <= ca_shift;
                        if (cnt == '0) begin
                            addr           <= ca_wa[MEM_AW-1:0];
                            dram_rwds_oe_l <= 1'b1;
                            dram_rwds_out  <= 1'b0;
                            cnt            <= CNT_W'(LAT_BEATS - 1);
                            odd            <= 1'b0;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    ST_LAT: if (beat) begin
                        if (cnt == '0) begin
                            odd <= 1'b0;
                            if (ca[CA_RW]) begin
                                dram_dq_oe_l   <= 1'b0;
                                dram_rwds_oe_l <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    ST_WDATA: if (beat) begin
                        odd <= !odd;
                        if (!odd) begin
                            hi_byte <= dram_dq_in;
                            hi_mask <= dram_rwds_in;
                        end else begin
                            wr_pend <= 1'b1;
                            wr_addr <= addr;
                            wr_data <= {hi_byte, dram_dq_in};
                            wr_be   <= {!hi_mask, !dram_rwds_in};
                            addr    <= addr + 1'b1;
                        end
                    end
                    ST_RDATA: if (beat) begin
                        odd           <= !odd;
                        dram_rwds_out <= !odd;
                        dram_dq_out   <= odd ? rd_word[7:0] : rd_word[15:8];
                        if (odd && !ca[CA_AS]) addr <= addr + 1'b1;
                    end
                    ST_REGW: if (beat) begin
                        odd <= !odd;
                        if (!odd) hi_byte <= dram_dq_in;
                        else      cr0     <= {hi_byte, dram_dq_in};
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hyper_resp.sv
// Randomized scoreboard bench for hyper_resp: a bus-level reference model predicts
// every read byte; an independent monitor pops and compares on each read beat.
module tb_hyper_resp;

    localparam int          DEPTH  = 1024;
    localparam int          LAT    = 22;
    localparam logic [15:0] ID0    = 16'h0C81;
    localparam logic [15:0] CR0R   = 16'h8F1F;

    logic        clk = 1'b0;
    logic        rst_l, dram_ck, dram_cs_l, dram_rst_l, dram_rwds_in;
    logic [7:0]  dram_dq_in, dram_dq_out;
    logic        dram_dq_oe_l, dram_rwds_out, dram_rwds_oe_l, busy;
    logic [15:0] cr0;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] ref_mem [DEPTH];
    logic [15:0] ref_cr0;
    logic [8:0]  exp_q [$];
    logic [15:0] wq [$];
    logic [1:0]  mq [$];

    always #5 clk = ~clk;

    hyper_resp dut (
        .clk            (clk),
        .rst_l          (rst_l),
        .dram_ck        (dram_ck),
        .dram_cs_l      (dram_cs_l),
        .dram_rst_l     (dram_rst_l),
        .dram_dq_in     (dram_dq_in),
        .dram_dq_out    (dram_dq_out),
        .dram_dq_oe_l   (dram_dq_oe_l),
        .dram_rwds_in   (dram_rwds_in),
        .dram_rwds_out  (dram_rwds_out),
        .dram_rwds_oe_l (dram_rwds_oe_l),
        .cr0            (cr0),
        .busy           (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic m);
        dram_dq_in   = d;
        dram_rwds_in = m;
        dram_ck      = ~dram_ck;
        tick();
        if ($urandom_range(0, 3) == 0) tick();
    endtask

    task automatic cs_start();
        dram_cs_l = 1'b0;
        tick();
        chk("ca_latency_ind", 32'({dram_rwds_oe_l, dram_rwds_out, busy}), 32'b011);
    endtask

    task automatic cs_end();
        dram_cs_l = 1'b1;
        tick();
        chk("cs_release", 32'({dram_dq_oe_l, dram_rwds_oe_l, busy}), 32'b110);
        tick();
    endtask

    task automatic send_ca(input logic rw, input logic as, input logic [31:0] a);
        logic [47:0] ca;
        ca = {rw, as, 1'($urandom_range(0, 1)), a[31:3], 13'($urandom), a[2:0]};
        for (int i = 5; i >= 0; i--) send_beat(ca[i*8 +: 8], 1'b0);
    endtask

    task automatic lat();
        repeat (LAT) send_beat(8'($urandom), 1'($urandom));
    endtask

    task automatic do_write(input int unsigned a);
        logic [15:0] w;
        logic [1:0]  m;
        int          idx;
        cs_start();
        send_ca(1'b0, 1'b0, a);
        lat();
        for (int i = 0; i < wq.size(); i++) begin
            w = wq[i];
            m = mq[i];
            send_beat(w[15:8], m[1]);
            send_beat(w[7:0], m[0]);
            idx = int'((a + 32'(i)) % DEPTH);
            if (!m[1]) ref_mem[idx][15:8] = w[15:8];
            if (!m[0]) ref_mem[idx][7:0]  = w[7:0];
        end
        cs_end();
        wq.delete();
        mq.delete();
    endtask

    task automatic do_read(input logic as, input int unsigned a, input int nbeats, input bit keep);
        logic [15:0] w;
        cs_start();
        send_ca(1'b1, as, a);
        lat();
        for (int b = 0; b < nbeats; b++) begin
            if (as) w = ((a % DEPTH) == 0) ? ID0 : ref_cr0;
            else    w = ref_mem[int'((a + 32'(b / 2)) % DEPTH)];
            exp_q.push_back((b % 2 == 0) ? {1'b1, w[15:8]} : {1'b0, w[7:0]});
            send_beat(8'($urandom), 1'($urandom));
        end
        tick();
        if (!keep) cs_end();
    endtask

    task automatic reg_write(input logic [15:0] v);
        cs_start();
        send_ca(1'b0, 1'b1, $urandom);
        send_beat(v[15:8], 1'b0);
        send_beat(v[7:0], 1'b0);
        ref_cr0 = v;
        chk("cr0_write", 32'(cr0), 32'(v));
        send_beat(~v[15:8], 1'b0);
        send_beat(~v[7:0], 1'b0);
        chk("cr0_after_done", 32'(cr0), 32'(v));
        cs_end();
    endtask

    task automatic chk_reset_vals(input string name);
        chk(name, 32'({dram_dq_out, dram_rwds_out, dram_dq_oe_l, dram_rwds_oe_l, busy}), 32'b00000000_0_1_1_0);
        chk({name, "_cr0"}, 32'(cr0), 32'(CR0R));
    endtask

    // Monitor: a read beat is a CK change with CS low while the DUT drives DQ;
    // its byte is checked on the following negedge.
    initial begin : monitor
        logic       pend;
        logic       mon_ck;
        logic [8:0] e;
        pend   = 1'b0;
        mon_ck = 1'b0;
        forever begin
            @(negedge clk);
            if (pend) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected: got %h with nothing expected", {dram_rwds_out, dram_dq_out});
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_byte", 32'({dram_rwds_out, dram_dq_out}), 32'(e));
                end
            end
            pend   = rst_l && dram_rst_l && !dram_cs_l && (dram_ck != mon_ck) && !dram_dq_oe_l;
            mon_ck = dram_ck;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: bench exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [15:0] keep_w;
        int          kind, n;
        int unsigned a;

        rst_l = 1'b0; dram_rst_l = 1'b1; dram_cs_l = 1'b1; dram_ck = 1'b0;
        dram_dq_in = '0; dram_rwds_in = 1'b0; ref_cr0 = CR0R;
        tick(); tick();
        chk_reset_vals("reset");
        rst_l = 1'b1;
        tick();

        // Fill the whole RAM so every later read has a known value.
        for (int i = 0; i < DEPTH; i++) begin
            wq.push_back(16'($urandom));
            mq.push_back(2'b00);
        end
        do_write(0);

        // Write then read two words.
        wq.push_back(16'hA55A); mq.push_back(2'b00);
        wq.push_back(16'h1234); mq.push_back(2'b00);
        do_write(32'h10);
        chk("model_a55a", 32'(ref_mem[16]), 32'h0000A55A);
        do_read(1'b0, 32'h10, 4, 1'b0);

        // Byte mask.
        wq.push_back(16'hFFFF); mq.push_back(2'b00);
        do_write(32'h20);
        wq.push_back(16'h00AB); mq.push_back(2'b10);
        do_write(32'h20);
        chk("model_ffab", 32'(ref_mem[32]), 32'h0000FFAB);
        do_read(1'b0, 32'h20, 2, 1'b0);

        // Register access.
        reg_write(16'h8F17);
        do_read(1'b1, 0, 4, 1'b0);
        do_read(1'b1, 1, 4, 1'b0);

        // Address wrap.
        wq.push_back(16'hBEEF); mq.push_back(2'b00);
        wq.push_back(16'hC0DE); mq.push_back(2'b00);
        do_write(DEPTH - 1);
        do_read(1'b0, DEPTH - 1, 4, 1'b0);
        do_read(1'b0, 0, 2, 1'b0);

        // Abort after one byte of a write word.
        cs_start();
        send_ca(1'b0, 1'b0, 32'h40);
        lat();
        send_beat(8'h5A, 1'b0);
        cs_end();
        do_read(1'b0, 32'h40, 2, 1'b0);

        // CS rise in the same cycle as the odd beat drops the word.
        cs_start();
        send_ca(1'b0, 1'b0, 32'h41);
        lat();
        send_beat(8'h33, 1'b0);
        dram_dq_in = 8'h44;
        dram_ck    = ~dram_ck;
        dram_cs_l  = 1'b1;
        tick();
        chk("cs_beat_release", 32'({dram_dq_oe_l, dram_rwds_oe_l, busy}), 32'b110);
        tick();
        do_read(1'b0, 32'h41, 2, 1'b0);

        // Abort a read mid-burst.
        do_read(1'b0, 32'h10, 3, 1'b0);

        // Randomized mix of transactions.
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 9);
            a    = $urandom;
            if (kind < 4) begin
                n = $urandom_range(1, 8);
                for (int i = 0; i < n; i++) begin
                    wq.push_back(16'($urandom));
                    mq.push_back(($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00);
                end
                do_write(a);
            end else if (kind < 8) begin
                do_read(1'b0, a, $urandom_range(1, 16), 1'b0);
            end else if (kind == 8) begin
                reg_write(16'($urandom));
            end else begin
                do_read(1'b1, $urandom_range(0, 3), $urandom_range(1, 6), 1'b0);
            end
        end

        // Reset asserted during a read.
        reg_write(16'h1357);
        keep_w = ref_mem[5];
        do_read(1'b0, 5, 3, 1'b1);
        rst_l = 1'b0;
        #1;
        chk_reset_vals("reset_mid_read");
        ref_cr0   = CR0R;
        dram_cs_l = 1'b1;
        tick();
        rst_l = 1'b1;
        tick();
        chk("mem_kept", 32'(ref_mem[5]), 32'(keep_w));
        do_read(1'b1, 1, 2, 1'b0);

        // Synchronous device reset.
        reg_write(16'h2468);
        dram_rst_l = 1'b0;
        tick();
        chk_reset_vals("dram_rst");
        ref_cr0    = CR0R;
        dram_rst_l = 1'b1;
        tick();
        do_read(1'b1, 2, 2, 1'b0);
        do_read(1'b0, 32'h20, 2, 1'b0);

        tick(); tick();
        chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hyper_resp.md
# hyper_resp

Synthesizable HyperBus responder: the device end of the link that `hyper_xface` initiates. It decodes the 48-bit command/address (CA) word, counts initial latency, and serves memory reads and writes from an internal 16-bit-wide RAM. It also serves register reads and writes (ID0, CR0). It replaces the behavioural `s27ks0641` model in FPGA loop-back and emulation builds, so the controller can be exercised without a real device.

## Interface
- `MEM_AW`, 10: log2 of RAM depth in 16-bit words.
- `LAT_BEATS`, 22: beats between the last CA beat and the first data beat (memory access, register read). Must match the controller's `latency_2x`.
- `ID0_VAL`, 16'h0C81: value returned for register read at word address 0.
- `CR0_RST`, 16'h8F1F: CR0 reset value.
- `clk` in 1: system clock, same clock the controller runs on.
- `rst_l` in 1: asynchronous active-low reset.
- `dram_ck` in 1: HyperBus clock from the controller.
- `dram_cs_l` in 1: chip select, active low.
- `dram_rst_l` in 1: device reset from the controller, active low, sampled synchronously.
- `dram_dq_in` in 8: DQ input.
- `dram_dq_out` out 8: DQ output.
- `dram_dq_oe_l` out 1: DQ output enable, active low.
- `dram_rwds_in` in 1: RWDS input, used as write byte mask.
- `dram_rwds_out` out 1: RWDS output.
- `dram_rwds_oe_l` out 1: RWDS output enable, active low.
- `cr0` out 16: current CR0 contents.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- **Beat definition.** A beat is any `clk` cycle where `dram_cs_l`=0 and `dram_ck` differs from its registered copy `ck_q`. One beat carries one byte.
- **State machine.** IDLE, CA, LAT, WDATA, RDATA, REGW, DONE.
  - IDLE → CA on `dram_cs_l` falling.
  - CA: shift in 6 beats, MSB byte first, into `ca[47:0]`.
  - After the 6th CA beat: register write (`ca[47]`=0, `ca[46]`=1) → REGW. All other accesses → LAT.
  - LAT: count `LAT_BEATS` beats, then → RDATA if `ca[47]`=1, else WDATA.
  - REGW: capture 2 beats into `cr0` (high byte first), then → DONE.
  - DONE: ignore beats until CS is released.
- **CS release.** `dram_cs_l`=1 in any state → IDLE on the next `clk`. Both output enables go to 1 in the same cycle. A partial word is discarded and memory is not written.
- **CA decode.**
  - `ca[47]`: 1 = read.
  - `ca[46]`: 1 = register space.
  - `ca[45]`: burst type, ignored; all bursts are linear.
  - Word address = `{ca[44:16], ca[2:0]}` truncated to `MEM_AW` bits.
- **Latency indication.** From CS falling until the end of CA, drive `dram_rwds_oe_l`=0 and `dram_rwds_out`=1 (fixed 2x latency).
- **Write data.**
  - Beats pair into words: even beat = `[15:8]`, odd beat = `[7:0]`.
  - `dram_rwds_in`=1 on a beat masks that byte.
  - The word is committed on its odd beat with per-byte enables, then the address increments.
- **Read data.**
  - Each beat outputs the next byte: high byte on even beats, low byte on odd beats.
  - `dram_rwds_out` = 1 on high-byte beats, 0 on low-byte beats.
  - `dram_dq_oe_l` and `dram_rwds_oe_l` are 0 for the whole of RDATA.
  - The address increments after each low byte.
  - Register read returns `ID0_VAL` at word address 0 and `cr0` at any other address; the address does not increment.
- **Address wrap.** The address wraps modulo 2^`MEM_AW`.
- **Device reset.** `dram_rst_l`=0 behaves like `rst_l`, applied synchronously.

## Timing
- **Reset values.**
  - `dram_dq_out`=0, `dram_rwds_out`=0.
  - `dram_dq_oe_l`=1, `dram_rwds_oe_l`=1.
  - `cr0`=`CR0_RST`, `busy`=0.
  - State = IDLE, all counters = 0.
- **CA latency indication.** `dram_rwds_oe_l` and `dram_rwds_out` are asserted the `clk` after CS is sampled low.
- **Read output.** Read bytes are registered: `dram_dq_out` updates 1 `clk` after the beat that requests the byte.
- **RAM prefetch.** RAM read latency is 1 `clk`. The next word is prefetched during the low-byte beat, so back-to-back beats never stall.
- **Write commit.** A RAM write occurs 1 `clk` after the odd beat.
- **CS release during a read.** Outputs tri-state no later than 1 `clk` after CS is sampled high.
- **Simultaneous events.** A CS rise in the same cycle as a beat takes priority: the beat is ignored.

## Structure
- **Package `hyper_pkg`** holds:
  - the state enum;
  - CA bit-position localparams (`CA_RW`=47, `CA_AS`=46, `CA_BT`=45);
  - `CA_BEATS`=6;
  - default `ID0`/`CR0` constants.
- **Sub-module `hyper_resp_mem`:** single-port 16-bit RAM with 2 byte-write enables and registered read.

## Test plan
1. **Memory write then read.** Write 2 words `16'hA55A`, `16'h1234` to address 0x10, then read 2 words from 0x10 → bytes A5 5A 12 34. RWDS toggles 1,0,1,0 during the read.
2. **Byte mask.** Write `16'hFFFF` to 0x20, then write `16'h00AB` with RWDS high on the first byte → readback `16'hFFAB`.
3. **Register access.** Register write `16'h8F17` → `cr0`=`16'h8F17` after 2 beats with no latency. Register read at address 0 → `16'h0C81`; at address 1 → `16'h8F17`.
4. **Address wrap.** Burst write of 2 words at address 2^`MEM_AW`−1 → the second word lands at address 0.
5. **Abort mid-operation.** CS released after 1 byte of a write word → memory unchanged, `busy`=0, both output enables = 1 next `clk`.
6. **Reset mid-read.** Assert `rst_l` low during RDATA → all outputs at reset values immediately, `cr0`=`16'h8F1F`.
